// File: rtl/alu_64bit_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pkg : shared width and opcode encoding for alu_64bit  (rev 1.0)
// ------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 64;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_64bit_if.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_64bit_if : operand/opcode bus and registered result  (rev 1.0)
// ------------------------------------------------------------------
interface alu_64bit_if;
  import alu_pkg::*;

  logic [ALU_W-1:0] a;
  logic [ALU_W-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic [ALU_W-1:0] s;
  logic             cout;

  modport master (output a, b, cin, op, input s, cout);
  modport slave  (input a, b, cin, op, output s, cout);

endinterface
`default_nettype wire

// File: rtl/alu_64bit_alu1bit.sv
`default_nettype none
// ------------------------------------------------------------------
// alu1bit : one-bit NOR / XOR / full-add / full-subtract slice  (rev 1.0)
// ------------------------------------------------------------------
module alu1bit
  import alu_pkg::*;
(
  input  wire logic       a,
  input  wire logic       b,
  input  wire logic       cin,
  input  wire logic [1:0] op,
  output logic            s,
  output logic            cout
);

  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_NOR: s = ~(a | b);
      OP_XOR: s = a ^ b;
      OP_ADD: begin
        s    = a ^ b ^ cin;
        cout = (a & b) | ((a ^ b) & cin);
      end
      default: begin
        // cin acts as borrow-in; cout is borrow-out
        s    = a ^ b ^ cin;
        cout = (~a & b) | (~(a ^ b) & cin);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_64bit.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_64bit : ripple-chain 64-bit ALU with registered result  (rev 1.0)
// ------------------------------------------------------------------
module alu_64bit
  import alu_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst_n,
  alu_64bit_if.slave  bus
);

  logic [ALU_W:0]   carry;
  logic [ALU_W-1:0] sum;
  logic             is_arith;
  logic [ALU_W-1:0] s_reg;
  logic             cout_reg;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < ALU_W; i++) begin : g_slice
    alu1bit u_slice (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (carry[i]),
      .op   (bus.op),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Chain value is meaningless for logic ops, so the output is masked.
  assign is_arith = (bus.op == OP_ADD) || (bus.op == OP_SUB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_reg    <= '0;
      cout_reg <= 1'b0;
    end else begin
      s_reg    <= sum;
      cout_reg <= carry[ALU_W] & is_arith;
    end
  end

  assign bus.s    = s_reg;
  assign bus.cout = cout_reg;

endmodule
`default_nettype wire

// File: tb/tb_alu_64bit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_64bit : directed self-checking bench for alu_64bit  (rev 1.0)
// ------------------------------------------------------------------
module tb_alu_64bit;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  alu_64bit_if bus ();

  alu_64bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector, then sample 1 time unit after the capturing edge.
  task automatic step(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                      input logic c);
    bus.op  = o;
    bus.a   = x;
    bus.b   = y;
    bus.cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(2'(i + 2), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      tests_run++;
      if (bus.s !== 64'h0) begin
        tests_failed++;
        $display("FAIL reset_s cycle %0d: got %h expected %h", i, bus.s, 64'h0);
      end
      tests_run++;
      if (bus.cout !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_cout cycle %0d: got %b expected 0", i, bus.cout);
      end
    end
    rst_n = 1'b1;
    step(2'b10, 64'd5, 64'd7, 1'b0);
    tests_run++;
    if (bus.s !== 64'd12) begin
      tests_failed++;
      $display("FAIL reset_release_add: got %h expected %h", bus.s, 64'd12);
    end
  endtask

  task automatic test_add_small();
    step(2'b10, 64'd0, 64'd0, 1'b0);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b0, 64'd0}) begin
      tests_failed++;
      $display("FAIL add_zero: got cout=%b s=%h expected cout=0 s=0", bus.cout, bus.s);
    end
    step(2'b10, 64'd1, 64'd1, 1'b0);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b0, 64'd2}) begin
      tests_failed++;
      $display("FAIL add_1p1: got cout=%b s=%h expected cout=0 s=2", bus.cout, bus.s);
    end
  endtask

  task automatic test_add_carry();
    step(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b1, 64'd0}) begin
      tests_failed++;
      $display("FAIL add_wrap_cin: got cout=%b s=%h expected cout=1 s=0", bus.cout, bus.s);
    end
    step(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b1, 64'd0}) begin
      tests_failed++;
      $display("FAIL add_msb_carry: got cout=%b s=%h expected cout=1 s=0", bus.cout, bus.s);
    end
  endtask

  task automatic test_sub_borrow();
    step(2'b11, 64'd10, 64'd3, 1'b0);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b0, 64'd7}) begin
      tests_failed++;
      $display("FAIL sub_10m3: got cout=%b s=%h expected cout=0 s=7", bus.cout, bus.s);
    end
    step(2'b11, 64'd0, 64'd1, 1'b0);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL sub_0m1: got cout=%b s=%h expected cout=1 s=all-ones", bus.cout, bus.s);
    end
    step(2'b11, 64'd5, 64'd5, 1'b1);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL sub_5m5m1: got cout=%b s=%h expected cout=1 s=all-ones", bus.cout, bus.s);
    end
  endtask

  task automatic test_logic();
    step(2'b00, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b0, 64'h000F_000F_000F_000F}) begin
      tests_failed++;
      $display("FAIL nor: got cout=%b s=%h expected cout=0 s=000f000f000f000f", bus.cout, bus.s);
    end
    step(2'b01, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1);
    tests_run++;
    if ({bus.cout, bus.s} !== {1'b0, 64'h0FF0_0FF0_0FF0_0FF0}) begin
      tests_failed++;
      $display("FAIL xor: got cout=%b s=%h expected cout=0 s=0ff00ff00ff00ff0", bus.cout, bus.s);
    end
  endtask

  // New inputs are applied before checking, so a result that follows the
  // current inputs instead of the registered ones shows up as an error.
  task automatic test_back_to_back();
    logic [1:0]  v_op   [7];
    logic [63:0] v_a    [7];
    logic [63:0] v_b    [7];
    logic        v_cin  [7];
    logic        v_rst  [7];
    logic [63:0] v_s    [7];
    logic        v_cout [7];
    v_op[0]=2'b10; v_a[0]=64'h0000_0000_FFFF_FFFF; v_b[0]=64'd1; v_cin[0]=1'b0; v_rst[0]=1'b1;
    v_s[0]=64'h0000_0001_0000_0000; v_cout[0]=1'b0;
    v_op[1]=2'b11; v_a[1]=64'd3; v_b[1]=64'd5; v_cin[1]=1'b0; v_rst[1]=1'b1;
    v_s[1]=64'hFFFF_FFFF_FFFF_FFFE; v_cout[1]=1'b1;
    v_op[2]=2'b00; v_a[2]=64'd0; v_b[2]=64'd0; v_cin[2]=1'b1; v_rst[2]=1'b1;
    v_s[2]=64'hFFFF_FFFF_FFFF_FFFF; v_cout[2]=1'b0;
    v_op[3]=2'b01; v_a[3]=64'hAAAA_AAAA_AAAA_AAAA; v_b[3]=64'h5555_5555_5555_5555; v_cin[3]=1'b1;
    v_rst[3]=1'b1; v_s[3]=64'hFFFF_FFFF_FFFF_FFFF; v_cout[3]=1'b0;
    v_op[4]=2'b10; v_a[4]=64'd1; v_b[4]=64'd1; v_cin[4]=1'b0; v_rst[4]=1'b0;
    v_s[4]=64'd0; v_cout[4]=1'b0;
    v_op[5]=2'b10; v_a[5]=64'd2; v_b[5]=64'd3; v_cin[5]=1'b1; v_rst[5]=1'b1;
    v_s[5]=64'd6; v_cout[5]=1'b0;
    v_op[6]=2'b11; v_a[6]=64'h8000_0000_0000_0000; v_b[6]=64'd1; v_cin[6]=1'b1; v_rst[6]=1'b1;
    v_s[6]=64'h7FFF_FFFF_FFFF_FFFE; v_cout[6]=1'b0;

    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        bus.op  = v_op[i];
        bus.a   = v_a[i];
        bus.b   = v_b[i];
        bus.cin = v_cin[i];
        rst_n   = v_rst[i];
      end else begin
        bus.op  = 2'b01;
        bus.a   = 64'h1234_5678_9ABC_DEF0;
        bus.b   = 64'h0;
        bus.cin = 1'b0;
        rst_n   = 1'b1;
      end
      #1;
      if (i > 0) begin
        tests_run++;
        if ({bus.cout, bus.s} !== {v_cout[i-1], v_s[i-1]}) begin
          tests_failed++;
          $display("FAIL pipe_vec%0d: got cout=%b s=%h expected cout=%b s=%h",
                   i - 1, bus.cout, bus.s, v_cout[i-1], v_s[i-1]);
        end
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.op       = 2'b00;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_small();
    test_add_carry();
    test_sub_borrow();
    test_logic();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
